// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: RAM/IO decode, output registers, synchronised inputs,
// sticky W1C rising-edge capture. Define MMIO_IO_IRQ_EN to add the MASK register and irq.
module mmio_io_ctrl #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                N_OUT    = 2,
  parameter int                OUT_W    = 8,
  parameter int                N_IN     = 2,
  parameter int                IN_W     = 8,
  parameter logic [ADDR_W-1:0] OUT_BASE = 9'h100,
  parameter logic [ADDR_W-1:0] IN_BASE  = 9'h140
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mem_cmd,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  input  logic [DATA_W-1:0]      ram_dout,
  output logic                   ram_write,
  input  logic [N_IN*IN_W-1:0]   sw_in,
  output logic [N_OUT*OUT_W-1:0] led_out,
  output logic                   irq
);

  localparam int SW_W = N_IN * IN_W;
  localparam int EW   = (SW_W < DATA_W) ? SW_W : DATA_W;
  localparam logic [ADDR_W-1:0] EDGE_ADDR = ADDR_W'(IN_BASE + N_IN);
  localparam logic [ADDR_W-1:0] MASK_ADDR = ADDR_W'(IN_BASE + N_IN + 1);

  logic                   is_rd, is_wr, io_sel, ram_sel;
  logic [N_OUT-1:0]       out_hit;
  logic [N_IN-1:0]        in_hit;
  logic                   edge_hit, mask_hit;

  logic [N_OUT*OUT_W-1:0] out_q, out_d;
  logic [SW_W-1:0]        s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [SW_W-1:0]        rise;
  logic [1:0]             warm_q, warm_d;
  logic [EW-1:0]          edge_q, edge_d, edge_set, edge_clr;
  logic [EW-1:0]          mask_q, mask_d;
  logic                   irq_q, irq_d;

  assign is_rd     = (mem_cmd == 2'b01);
  assign is_wr     = (mem_cmd == 2'b10);
  assign io_sel    = mem_addr[ADDR_W-1];
  assign ram_sel   = ~io_sel;
  assign ram_write = ram_sel & is_wr;
  assign led_out   = out_q;

  always_comb begin
    out_hit  = '0;
    in_hit   = '0;
    edge_hit = io_sel && (mem_addr == EDGE_ADDR);
`ifdef MMIO_IO_IRQ_EN
    mask_hit = io_sel && (mem_addr == MASK_ADDR);
`else
    mask_hit = 1'b0;
`endif
    for (int k = 0; k < N_OUT; k++)
      out_hit[k] = io_sel && (mem_addr == ADDR_W'(OUT_BASE + k));
    for (int k = 0; k < N_IN; k++)
      in_hit[k] = io_sel && (mem_addr == ADDR_W'(IN_BASE + k));
  end

  // Warm-up counter holds off edge capture until the synchroniser holds real samples.
  always_comb begin
    out_d = out_q;
    for (int k = 0; k < N_OUT; k++)
      if (is_wr && out_hit[k]) out_d[k*OUT_W +: OUT_W] = write_data[OUT_W-1:0];
    s1_d     = sw_in;
    s2_d     = s1_q;
    prev_d   = s2_q;
    warm_d   = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    rise     = s2_q & ~prev_q;
    edge_set = (warm_q == 2'd3) ? rise[EW-1:0] : '0;
    edge_clr = (is_wr && edge_hit) ? write_data[EW-1:0] : '0;
    edge_d   = (edge_q & ~edge_clr) | edge_set;
    mask_d   = (is_wr && mask_hit) ? write_data[EW-1:0] : mask_q;
`ifdef MMIO_IO_IRQ_EN
    irq_d    = |(edge_d & mask_d);
`else
    irq_d    = 1'b0;
`endif
  end

  always_comb begin
    read_data = '0;
    if (is_rd) begin
      if (ram_sel) begin
        read_data = ram_dout;
      end else begin
        for (int k = 0; k < N_OUT; k++)
          if (out_hit[k]) read_data[OUT_W-1:0] = out_q[k*OUT_W +: OUT_W];
        for (int k = 0; k < N_IN; k++)
          if (in_hit[k]) read_data[IN_W-1:0] = s2_q[k*IN_W +: IN_W];
        if (edge_hit) read_data[EW-1:0] = edge_q;
        if (mask_hit) read_data[EW-1:0] = mask_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      warm_q <= '0;
      edge_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      warm_q <= warm_d;
      edge_q <= edge_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl: sample-history model checked every negedge, plus directed literal checks.
module tb_mmio_io_ctrl;

  localparam logic [1:0] MNONE = 2'b00, MREAD = 2'b01, MWRITE = 2'b10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mem_cmd = MNONE;
  logic [8:0]  mem_addr = '0;
  logic [15:0] write_data = '0;
  logic [15:0] read_data;
  logic [15:0] ram_dout = '0;
  logic        ram_write;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  mmio_io_ctrl dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(read_data), .ram_dout(ram_dout),
    .ram_write(ram_write), .sw_in(sw_in), .led_out(led_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: samp0/1/2 are sw_in as seen at the last three rising edges.
  logic [7:0]  m_out [2];
  logic [15:0] samp0 = '0, samp1 = '0, samp2 = '0;
  logic [15:0] m_edge = '0, m_mask = '0, m_rise, m_clr;
  logic        m_irq = 1'b0;
  int          since_release = 0;

  initial begin
    m_out[0] = '0;
    m_out[1] = '0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_out[0] = '0; m_out[1] = '0;
      samp0 = '0; samp1 = '0; samp2 = '0;
      m_edge = '0; m_mask = '0; m_irq = 1'b0;
      since_release = 0;
    end else begin
      m_rise = (since_release >= 3) ? (samp1 & ~samp2) : 16'h0;
      m_clr  = (mem_cmd == MWRITE && mem_addr == 9'h142) ? write_data : 16'h0;
      m_edge = (m_edge & ~m_clr) | m_rise;
`ifdef MMIO_IO_IRQ_EN
      if (mem_cmd == MWRITE && mem_addr == 9'h143) m_mask = write_data;
      m_irq = |(m_edge & m_mask);
`endif
      if (mem_cmd == MWRITE && (mem_addr == 9'h100 || mem_addr == 9'h101))
        m_out[mem_addr - 9'h100] = write_data[7:0];
      samp2 = samp1;
      samp1 = samp0;
      samp0 = sw_in;
      if (since_release < 3) since_release++;
    end
  end

  function automatic logic [15:0] exp_rd();
    int off_o, off_i;
    if (mem_cmd != MREAD) return 16'h0;
    if (!mem_addr[8]) return ram_dout;
    off_o = int'(mem_addr) - 'h100;
    off_i = int'(mem_addr) - 'h140;
    if (off_o >= 0 && off_o < 2) return {8'h00, m_out[off_o]};
    if (off_i >= 0 && off_i < 2) return {8'h00, samp1[off_i*8 +: 8]};
    if (off_i == 2) return m_edge;
`ifdef MMIO_IO_IRQ_EN
    if (off_i == 3) return m_mask;
`endif
    return 16'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model led_out", 32'(led_out), {16'h0, m_out[1], m_out[0]});
    chk("model ram_write", 32'(ram_write), 32'(mem_cmd == MWRITE && !mem_addr[8]));
    chk("model read_data", 32'(read_data), 32'(exp_rd()));
    chk("model irq", 32'(irq), 32'(m_irq));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
  endtask

  task automatic rd_chk(input string name, input logic [8:0] addr, input logic [15:0] exp);
    op(MREAD, addr, 16'h0);
    #1;
    chk(name, 32'(read_data), 32'(exp));
  endtask

  initial begin
    #1 reset = 1'b0;
    sw_in = 16'h00FF;
    // T1: inputs already high at release must not record an edge
    repeat (3) tick();
    chk("reset led_out", 32'(led_out), 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    rd_chk("reset out0", 9'h100, 16'h0000);
    op(MNONE, 9'h0, 16'h0);
    reset = 1'b1;
    repeat (4) tick();
    rd_chk("T1 in0", 9'h140, 16'h00FF);
    rd_chk("T1 in1", 9'h141, 16'h0000);
    rd_chk("T1 edge", 9'h142, 16'h0000);

    // T2: output registers
    op(MWRITE, 9'h100, 16'h12A5);
    tick();
    chk("T2 led0", 32'(led_out[7:0]), 32'hA5);
    rd_chk("T2 out0", 9'h100, 16'h00A5);
    op(MWRITE, 9'h101, 16'hFF33);
    tick();
    chk("T2 led", 32'(led_out), 32'h33A5);
    op(MWRITE, 9'h140, 16'hFFFF);
    tick();
    rd_chk("T2 in ro", 9'h140, 16'h00FF);
    rd_chk("T2 out1", 9'h101, 16'h0033);

    // T3: edge capture latency and W1C
    sw_in = 16'h0000;
    repeat (4) tick();
    sw_in = 16'h0005;
    tick();
    tick();
    rd_chk("T3 edge early", 9'h142, 16'h0000);
    tick();
    #1 chk("T3 edge set", 32'(read_data), 32'h0005);
    op(MWRITE, 9'h142, 16'h0001);
    tick();
    rd_chk("T3 w1c", 9'h142, 16'h0004);

    // T4: set wins over simultaneous clear
    op(MWRITE, 9'h142, 16'h0004);
    tick();
    rd_chk("T4 cleared", 9'h142, 16'h0000);
    sw_in = 16'h0001;
    repeat (4) tick();
    sw_in = 16'h0005;
    tick();
    tick();
    op(MWRITE, 9'h142, 16'h0004);
    tick();
    rd_chk("T4 set wins", 9'h142, 16'h0004);
    rd_chk("T4 in0", 9'h140, 16'h0005);
    op(MWRITE, 9'h142, 16'h0004);
    tick();
    rd_chk("T4 w1c", 9'h142, 16'h0000);

    // T5: RAM path and unmapped I/O
    op(MWRITE, 9'h010, 16'hBEEF);
    #1 chk("T5 ram_write hi", 32'(ram_write), 32'h1);
    tick();
    op(MNONE, 9'h010, 16'h0);
    #1 chk("T5 ram_write lo", 32'(ram_write), 32'h0);
    op(2'b11, 9'h010, 16'hBEEF);
    #1 chk("T5 cmd11 ram_write", 32'(ram_write), 32'h0);
    ram_dout = 16'hBEEF;
    rd_chk("T5 ram read", 9'h010, 16'hBEEF);
    rd_chk("T5 unmapped", 9'h1F0, 16'h0000);
    op(MWRITE, 9'h100, 16'h0000);
    #1 chk("T5 io no ram_write", 32'(ram_write), 32'h0);
    tick();
    op(MWRITE, 9'h100, 16'h00A5);
    tick();

    // T6: mask and irq
    op(MWRITE, 9'h143, 16'h0001);
    tick();
`ifdef MMIO_IO_IRQ_EN
    rd_chk("T6 mask", 9'h143, 16'h0001);
`else
    rd_chk("T6 mask absent", 9'h143, 16'h0000);
`endif
    sw_in = 16'h0004;
    repeat (4) tick();
    sw_in = 16'h0005;
    tick();
    tick();
    chk("T6 irq before", 32'(irq), 32'h0);
    op(MREAD, 9'h142, 16'h0);
    tick();
    #1 chk("T6 edge", 32'(read_data), 32'h0001);
`ifdef MMIO_IO_IRQ_EN
    chk("T6 irq set", 32'(irq), 32'h1);
`else
    chk("T6 irq tied", 32'(irq), 32'h0);
`endif
    op(MWRITE, 9'h142, 16'h0001);
    tick();
    chk("T6 irq clr", 32'(irq), 32'h0);

    // reset in the middle of a write to OUT
    op(MWRITE, 9'h100, 16'h00FF);
    #2 reset = 1'b0;
    #1 chk("rst led_out", 32'(led_out), 32'h0);
    chk("rst irq", 32'(irq), 32'h0);
    tick();
    chk("rst held led_out", 32'(led_out), 32'h0);
    op(MNONE, 9'h0, 16'h0);
    reset = 1'b1;
    tick();
    rd_chk("rst out0", 9'h100, 16'h0000);
    rd_chk("rst edge", 9'h142, 16'h0000);
    op(MNONE, 9'h0, 16'h0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
